wishbone_slave_xactor: RTL and testbench

Pipelined Wishbone B4 slave transactor that terminates the bus driven by the Wishbone master transactor and presents it to a local client as a request/response server pair with BSV-style EN/RDY handshakes. It buffers accepted bus requests, returns one registered ACK per request in issue order, applies STALL back-pressure, and cleanly discards in-flight work when the master drops CYC.

---
 rtl/wishbone_slave_xactor_pkg.sv | 24 ++
 rtl/wishbone_slave_xactor_if.sv | 32 +++
 rtl/wb_sync_fifo.sv | 57 +++++
 rtl/wishbone_slave_xactor.sv | 137 +++++++++++++
 tb/tb_wishbone_slave_xactor.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wishbone_slave_xactor_pkg.sv
// Wishbone request bundle and width helpers, shared by the
// master and slave transactors.
package wishbone_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;
  localparam int WB_REQ_W  = 1 + WB_SEL_W + WB_ADDR_W + WB_DATA_W;

  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;

  function automatic int wb_req_width(
    input int aw,
    input int dw
  );
    return 1 + dw / 8 + aw + dw;
  endfunction

endpackage

// File: rtl/wishbone_slave_xactor_if.sv
// Pipelined Wishbone B4 bus, signal names seen from the slave.
// The master modport drives the *_I side.
interface wb_if
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W
);

  logic                    CYC_I;
  logic                    STB_I;
  logic                    WE_I;
  logic [ADDR_WIDTH-1:0]   ADR_I;
  logic [DATA_WIDTH/8-1:0] SEL_I;
  logic [DATA_WIDTH-1:0]   DAT_I;
  logic                    STALL_O;
  logic                    ACK_O;
  logic [DATA_WIDTH-1:0]   DAT_O;

  modport master (
    output CYC_I, STB_I, WE_I,
    output ADR_I, SEL_I, DAT_I,
    input  STALL_O, ACK_O, DAT_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I,
    input  ADR_I, SEL_I, DAT_I,
    output STALL_O, ACK_O, DAT_O
  );

endinterface

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO with a synchronous clear and a
// show-ahead head output; push is allowed when full if popping.
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/wishbone_slave_xactor.sv
// Wishbone B4 pipelined slave: buffers bus requests for a local
// client and returns one registered ACK per request, in order.
module wishbone_slave_xactor
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH      = WB_ADDR_W,
  parameter int DATA_WIDTH      = WB_DATA_W,
  parameter int REQ_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic CLK,
  input  logic RST,
  wb_if.slave  wb,

  output logic [wb_req_width(ADDR_WIDTH, DATA_WIDTH)-1:0]
               client_request_get,
  output logic RDY_client_request_get,
  input  logic EN_client_request_get,

  input  logic [DATA_WIDTH-1:0] client_response_put,
  input  logic EN_client_response_put,
  output logic RDY_client_response_put
);

  localparam int RW = wb_req_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         r_drop;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dat;

  logic                  w_req_full;
  logic                  w_req_empty;
  logic                  w_rsp_full;
  logic                  w_rsp_empty;
  logic [DATA_WIDTH-1:0] w_rsp_head;
  logic                  w_draining;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_live;
  logic                  w_ack;
  logic                  w_rsp_push;
  logic                  w_rsp_pop;
  logic [DATA_WIDTH-1:0] w_ack_dat;
  logic [CW-1:0]         w_inflight_nxt;
  logic [RW-1:0]         w_req_in;

  assign w_draining = (r_drop != '0);
  assign w_stall    = RST | w_req_full | w_draining
                    | (r_outstanding == MAX_CNT);
  assign w_accept   = wb.CYC_I & wb.STB_I & ~w_stall;
  assign w_clear    = RST | ~wb.CYC_I;
  assign w_live     = wb.CYC_I & ~w_draining;

  // An empty response FIFO lets a fresh put bypass straight to ACK.
  assign w_ack      = w_live
                    & (~w_rsp_empty | EN_client_response_put);
  assign w_rsp_pop  = w_live & ~w_rsp_empty;
  assign w_rsp_push = w_live & ~w_rsp_empty
                    & EN_client_response_put;
  assign w_ack_dat  = w_rsp_empty ? client_response_put
                                  : w_rsp_head;

  assign w_inflight_nxt = r_inflight
                        + CW'(EN_client_request_get)
                        - CW'(EN_client_response_put);

  assign w_req_in = {wb.WE_I, wb.SEL_I, wb.ADR_I, wb.DAT_I};

  wb_sync_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (RW)
  ) u_req_fifo (
    .clk     (CLK),
    .i_clear (w_clear),
    .i_push  (w_accept),
    .i_pop   (EN_client_request_get),
    .i_data  (w_req_in),
    .o_full  (w_req_full),
    .o_empty (w_req_empty),
    .o_head  (client_request_get)
  );

  wb_sync_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (CLK),
    .i_clear (w_clear),
    .i_push  (w_rsp_push),
    .i_pop   (w_rsp_pop),
    .i_data  (client_response_put),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_head  (w_rsp_head)
  );

  assign wb.STALL_O = w_stall;
  assign wb.ACK_O   = r_ack;
  assign wb.DAT_O   = r_dat;

  assign RDY_client_request_get  = ~RST & ~w_req_empty
                                 & ~w_draining;
  assign RDY_client_response_put = ~RST & ~w_rsp_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_outstanding <= '0;
      r_inflight    <= '0;
      r_drop        <= '0;
      r_ack         <= 1'b0;
      r_dat         <= '0;
    end else begin
      r_ack      <= w_ack;
      r_inflight <= w_inflight_nxt;
      if (w_ack) r_dat <= w_ack_dat;

      if (!wb.CYC_I) r_outstanding <= '0;
      else r_outstanding <= r_outstanding
                          + CW'(w_accept) - CW'(w_ack);

      // Responses owed for requests of an aborted cycle are swallowed.
      unique case (1'b1)
        !wb.CYC_I:
          r_drop <= w_inflight_nxt;
        wb.CYC_I && w_draining && EN_client_response_put:
          r_drop <= r_drop - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_slave_xactor.sv
// Bench for wishbone_slave_xactor: directed table, corner
// sequences and random traffic against a queue-based model.
module tb_wishbone_slave_xactor;
  import wishbone_pkg::*;

  localparam int REQ_DEPTH = 2;
  localparam int MAX_OUT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_get = 1'b0;
  logic        en_put = 1'b0;
  logic [31:0] rsp_dat = '0;
  logic [68:0] req_get;
  logic        rdy_get;
  logic        rdy_put;

  int total = 0;
  int bad   = 0;

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wishbone_slave_xactor #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .REQ_DEPTH       (REQ_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .CLK                     (clk),
    .RST                     (rst),
    .wb                      (bus),
    .client_request_get      (req_get),
    .RDY_client_request_get  (rdy_get),
    .EN_client_request_get   (en_get),
    .client_response_put     (rsp_dat),
    .EN_client_response_put  (en_put),
    .RDY_client_response_put (rdy_put)
  );

  always #5 clk = ~clk;

  // reference model state
  wb_req_t     m_req[$];
  logic [31:0] m_rsp[$];
  int          m_out  = 0;
  int          m_infl = 0;
  int          m_drop = 0;
  logic        m_ack  = 1'b0;
  logic [31:0] m_dat  = '0;
  bit          pend   = 1'b0;

  function automatic bit f_stall(input bit r);
    return r || m_req.size() == REQ_DEPTH
             || m_out == MAX_OUT || m_drop != 0;
  endfunction

  function automatic bit f_rg(input bit r);
    return !r && m_req.size() != 0 && m_drop == 0;
  endfunction

  function automatic bit f_rp(input bit r);
    return !r && m_rsp.size() < MAX_OUT;
  endfunction

  task automatic chk(input string nm,
                     input logic [68:0] act,
                     input logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  // advance the model by one clock using the inputs now applied
  task automatic commit();
    bit acc;
    pend = 1'b0;
    if (rst) begin
      m_req.delete();
      m_rsp.delete();
      m_out  = 0;
      m_infl = 0;
      m_drop = 0;
      m_ack  = 1'b0;
      m_dat  = '0;
      return;
    end
    acc = bus.CYC_I && bus.STB_I && !f_stall(1'b0);
    if (en_get) void'(m_req.pop_front());
    m_infl += int'(en_get) - int'(en_put);
    if (!bus.CYC_I) begin
      m_req.delete();
      m_rsp.delete();
      m_out  = 0;
      m_drop = m_infl;
      m_ack  = 1'b0;
    end else if (m_drop > 0) begin
      if (en_put) m_drop--;
      m_ack = 1'b0;
    end else begin
      if (en_put) m_rsp.push_back(rsp_dat);
      if (m_rsp.size() > 0) begin
        m_ack = 1'b1;
        m_dat = m_rsp.pop_front();
        m_out--;
      end else begin
        m_ack = 1'b0;
      end
      if (acc) begin
        m_req.push_back(wb_req_t'{we: bus.WE_I,
          sel: bus.SEL_I, adr: bus.ADR_I, dat: bus.DAT_I});
        m_out++;
      end
    end
  endtask

  task automatic check_model();
    chk("stall", 69'(bus.STALL_O), 69'(f_stall(rst)));
    chk("ack", 69'(bus.ACK_O), 69'(m_ack));
    chk("dat_o", 69'(bus.DAT_O), 69'(m_dat));
    chk("rdy_get", 69'(rdy_get), 69'(f_rg(rst)));
    chk("rdy_put", 69'(rdy_put), 69'(f_rp(rst)));
    if (f_rg(rst)) chk("req", req_get, 69'(m_req[0]));
  endtask

  task automatic step(input bit r, c, s, w,
                      input logic [31:0] a,
                      input logic [3:0]  sl,
                      input logic [31:0] wd,
                      input bit p, u,
                      input logic [31:0] pd);
    if (pend) commit();
    @(negedge clk);
    rst       = r;
    bus.CYC_I = c;
    bus.STB_I = s;
    bus.WE_I  = w;
    bus.ADR_I = a;
    bus.SEL_I = sl;
    bus.DAT_I = wd;
    en_get    = p;
    en_put    = u;
    rsp_dat   = pd;
    #1;
    check_model();
    pend = 1'b1;
  endtask

  // legal client behaviour chosen from the model's view
  task automatic rnd_cycle(input bit r, c, s, input int pct);
    bit p;
    bit u;
    if (pend) commit();
    p = f_rg(r) && $urandom_range(0, 99) < pct;
    u = f_rp(r) && (m_infl + int'(p)) > 0
        && $urandom_range(0, 99) < pct;
    step(r, c, s, 1'($urandom), $urandom, 4'($urandom),
         $urandom, p, u, $urandom);
  endtask

  typedef struct {
    logic [3:0]  ctl;  // rst cyc stb we
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [1:0]  cli;  // pop put
    logic [31:0] pdat;
    logic [3:0]  exp;  // stall ack rdy_get rdy_put
    logic [31:0] edat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = '0;
    bus.SEL_I = '0;
    bus.DAT_I = '0;

    tbl[0]  = '{4'b1000, 32'h0, 32'h0, 2'b00, 32'h0,
                4'b1000, 32'h0};
    tbl[1]  = '{4'b1000, 32'h0, 32'h0, 2'b00, 32'h0,
                4'b1000, 32'h0};
    tbl[2]  = '{4'b0110, 32'h100, 32'h0, 2'b00, 32'h0,
                4'b0001, 32'h0};
    tbl[3]  = '{4'b0100, 32'h0, 32'h0, 2'b11, 32'hDEADBEEF,
                4'b0011, 32'h0};
    tbl[4]  = '{4'b0100, 32'h0, 32'h0, 2'b00, 32'h0,
                4'b0101, 32'hDEADBEEF};
    tbl[5]  = '{4'b0100, 32'h0, 32'h0, 2'b00, 32'h0,
                4'b0001, 32'hDEADBEEF};
    tbl[6]  = '{4'b0111, 32'h200, 32'h11, 2'b00, 32'h0,
                4'b0001, 32'hDEADBEEF};
    tbl[7]  = '{4'b0111, 32'h204, 32'h22, 2'b11, 32'hA0,
                4'b0011, 32'hDEADBEEF};
    tbl[8]  = '{4'b0111, 32'h208, 32'h33, 2'b11, 32'hA1,
                4'b0111, 32'hA0};
    tbl[9]  = '{4'b0111, 32'h20C, 32'h44, 2'b11, 32'hA2,
                4'b0111, 32'hA1};
    tbl[10] = '{4'b0100, 32'h0, 32'h0, 2'b11, 32'hA3,
                4'b0111, 32'hA2};
    tbl[11] = '{4'b0100, 32'h0, 32'h0, 2'b00, 32'h0,
                4'b0101, 32'hA3};
    tbl[12] = '{4'b0100, 32'h0, 32'h0, 2'b00, 32'h0,
                4'b0001, 32'hA3};

    // reset, single read, 4-write burst
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1],
           tbl[i].ctl[0], tbl[i].adr, 4'hF, tbl[i].wdat,
           tbl[i].cli[1], tbl[i].cli[0], tbl[i].pdat);
      chk($sformatf("t%0d_stall", i),
          69'(bus.STALL_O), 69'(tbl[i].exp[3]));
      chk($sformatf("t%0d_ack", i),
          69'(bus.ACK_O), 69'(tbl[i].exp[2]));
      chk($sformatf("t%0d_rdy_get", i),
          69'(rdy_get), 69'(tbl[i].exp[1]));
      chk($sformatf("t%0d_rdy_put", i),
          69'(rdy_put), 69'(tbl[i].exp[0]));
      chk($sformatf("t%0d_dat_o", i),
          69'(bus.DAT_O), 69'(tbl[i].edat));
    end

    // back-pressure: silent client, stall after REQ_DEPTH
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h300 + 32'(4 * i),
           4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("bp_stall", 69'(bus.STALL_O), 69'(i >= 2));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("bp_clr_stall", 69'(bus.STALL_O), 69'(0));
    chk("bp_clr_rdy", 69'(rdy_get), 69'(0));

    // abort with two popped requests owed by the client
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 4'hF, 32'h0,
         1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h404, 4'hF, 32'h0,
         1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h408, 4'hF, 32'h0,
         1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0,
         1'b0, 1'b1, 32'h1);
    chk("ab_ack", 69'(bus.ACK_O), 69'(0));
    chk("ab_stall0", 69'(bus.STALL_O), 69'(1));
    chk("ab_rdy_get", 69'(rdy_get), 69'(0));
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0,
         1'b0, 1'b1, 32'h2);
    chk("ab_stall1", 69'(bus.STALL_O), 69'(1));
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("ab_stall2", 69'(bus.STALL_O), 69'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b1, 1'b1, 32'hCAFEF00D);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("ab_new_ack", 69'(bus.ACK_O), 69'(1));
    chk("ab_new_dat", 69'(bus.DAT_O), 69'(32'hCAFEF00D));

    // accept and ACK together at MAX_OUTSTANDING-1
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h600, 4'hF, 32'h0,
         1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h604, 4'hF, 32'h0,
         1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h608, 4'hF, 32'h0,
         1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h60C, 4'hF, 32'h0,
         1'b1, 1'b1, 32'h1111);
    chk("sim_stall0", 69'(bus.STALL_O), 69'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("sim_ack", 69'(bus.ACK_O), 69'(1));
    chk("sim_dat", 69'(bus.DAT_O), 69'(32'h1111));
    chk("sim_stall1", 69'(bus.STALL_O), 69'(0));
    for (int k = 0; k < 10; k++) rnd_cycle(1'b0, 1'b1, 1'b0, 100);

    // reset in the middle of a burst
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h700, 4'hF, 32'h0,
         1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h704, 4'hF, 32'h0,
         1'b1, 1'b1, 32'h7070);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h708, 4'hF, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("rst_stall", 69'(bus.STALL_O), 69'(1));
    chk("rst_rdy_get", 69'(rdy_get), 69'(0));
    chk("rst_rdy_put", 69'(rdy_put), 69'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("rst_ack", 69'(bus.ACK_O), 69'(0));
    chk("rst_dat", 69'(bus.DAT_O), 69'(0));
    chk("rst_stall_rel", 69'(bus.STALL_O), 69'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
         1'b0, 1'b0, 32'h0);
    chk("rst_no_ack", 69'(bus.ACK_O), 69'(0));

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      bit r;
      bit c;
      bit s;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 19) != 0);
      s = ($urandom_range(0, 1) == 1);
      rnd_cycle(r, c, s, 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
